// File: rtl/mpa_pkg.sv
// Shared types and default sizing for the multi-precision adder sequencer.
package mpa_pkg;

    localparam int unsigned MPA_WORD_WIDTH = 12;
    localparam int unsigned MPA_LEN_WIDTH  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } mpa_state_e;

endpackage

// File: rtl/mpa_chunk_adder.sv
// One word slice of the multi-precision adder: generate/propagate sum with a
// group-lookahead carry-out so the inter-word carry does not wait on the sum chain.
module mpa_chunk_adder
    import mpa_pkg::*;
#(
    parameter int unsigned WIDTH = MPA_WORD_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH-1:0] carry;
    logic             grp_gen;
    logic             grp_prop;

    // Per-bit carries for the sum, group generate/propagate for the carry-out.
    always_comb begin
        gen      = A & B;
        prop     = A ^ B;
        carry    = '0;
        carry[0] = Cin;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            carry[i] = gen[i-1] | (prop[i-1] & carry[i-1]);
        end
        Sum      = prop ^ carry;
        grp_gen  = 1'b0;
        grp_prop = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            grp_gen  = gen[i] | (prop[i] & grp_gen);
            grp_prop = grp_prop & prop[i];
        end
        Cout = grp_gen | (grp_prop & Cin);
    end

endmodule

// File: rtl/mpa_add_sequencer.sv
// Multi-precision add sequencer: streams LSW-first operand words through one
// chunk adder, carrying between beats, with valid/ready on both sides.
// Optional subtract mode is enabled by defining MPA_SUB_EN (adds port iSub).
module mpa_add_sequencer
    import mpa_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = MPA_WORD_WIDTH,
    parameter int unsigned LEN_WIDTH  = MPA_LEN_WIDTH
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iStart,
    input  logic [LEN_WIDTH-1:0]  iLen,
    input  logic                  iCin,
`ifdef MPA_SUB_EN
    input  logic                  iSub,
`endif
    output logic                  oBusy,
    input  logic [WORD_WIDTH-1:0] iA,
    input  logic [WORD_WIDTH-1:0] iB,
    input  logic                  iValid,
    output logic                  oReady,
    output logic [WORD_WIDTH-1:0] oSum,
    output logic                  oValid,
    input  logic                  iReady,
    output logic                  oLast,
    output logic                  oCout,
    output logic                  oDone
);

    mpa_state_e            state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic                  carry_q, carry_d;
    logic [WORD_WIDTH-1:0] sum_q, sum_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  cout_q, cout_d;
    logic                  done_q, done_d;
    logic                  ready_c;
    logic                  carry_seed;

    logic [WORD_WIDTH-1:0] add_b;
    logic [WORD_WIDTH-1:0] add_sum;
    logic                  add_cout;

`ifdef MPA_SUB_EN
    logic                  sub_q, sub_d;

    // Subtraction is A + ~B + 1 across the whole operand, so the seed is forced high.
    always_comb begin
        add_b      = sub_q ? ~iB : iB;
        carry_seed = iSub ? 1'b1 : iCin;
        sub_d      = sub_q;
        if (state_q == IDLE && iStart && iLen != '0) begin
            sub_d = iSub;
        end
    end
`else
    // Addition only: operand B passes straight through and iCin seeds the chain.
    always_comb begin
        add_b      = iB;
        carry_seed = iCin;
    end
`endif

    mpa_chunk_adder #(
        .WIDTH (WORD_WIDTH)
    ) u_chunk_adder (
        .A    (iA),
        .B    (add_b),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Next-state and output-register logic for IDLE/RUN/DRAIN.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        last_d  = last_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        ready_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (iStart && iLen != '0) begin
                    len_d   = iLen;
                    carry_d = carry_seed;
                    count_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ready_c = !valid_q || iReady;
                if (iValid && ready_c) begin
                    sum_d   = add_sum;
                    valid_d = 1'b1;
                    carry_d = add_cout;
                    count_d = count_q + LEN_WIDTH'(1);
                    if (count_q == len_q - LEN_WIDTH'(1)) begin
                        last_d  = 1'b1;
                        cout_d  = add_cout;
                        state_d = DRAIN;
                    end
                end else if (valid_q && iReady) begin
                    valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (valid_q && iReady) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

`ifdef MPA_SUB_EN
    // Operation mode register, captured with the start parameters.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`endif

    assign oReady = ready_c;
    assign oSum   = sum_q;
    assign oValid = valid_q;
    assign oLast  = last_q;
    assign oCout  = cout_q;
    assign oDone  = done_q;
    // The done cycle is already back in IDLE, yet still counts as busy.
    assign oBusy  = (state_q != IDLE) || done_q;

endmodule
